data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder.sv | 119 +++++++++++
 tb/tb_data_bus_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Memory-mapped CPU data-bus slave: data RAM, LED register, free-running counter
// with compare/match interrupt, and an output FIFO drained by a ready/valid sink.
module data_bus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  led,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = (RAM_WORDS  > 1) ? $clog2(RAM_WORDS)  : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic ram;
    logic led;
    logic cnt;
    logic cmp;
    logic sts;
    logic push;
  } sel_t;

  sel_t        sel;
  logic [29:0] wa;
  logic [AW-1:0] ridx;

  logic [31:0] ram  [RAM_WORDS];
  logic [31:0] fmem [FIFO_DEPTH];
  logic [31:0] count, compare;
  logic        match, ovf;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] fcnt;

  logic wr, push, pop, full, empty, push_ok, drop;
  logic unused;

  assign wa     = ALUResult[31:2];
  assign unused = ^ALUResult[1:0];
  // RAM aliases modulo RAM_WORDS inside the 256-byte window
  assign ridx   = AW'(ALUResult[7:2] & 6'(RAM_WORDS - 1));

  always_comb begin
    sel      = '0;
    sel.ram  = (ALUResult[31:8] == 24'd0);
    sel.led  = (wa == 30'h40);
    sel.cnt  = (wa == 30'h41);
    sel.cmp  = (wa == 30'h42);
    sel.sts  = (wa == 30'h43);
    sel.push = (wa == 30'h44);
  end

  assign wr      = MemWrite;
  assign push    = wr & sel.push;
  assign pop     = out_valid & out_ready;
  assign full    = (fcnt == CW'(FIFO_DEPTH));
  assign empty   = (fcnt == '0);
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign out_valid = ~empty;
  assign out_data  = fmem[rptr];
  assign irq       = match;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led     <= '0;
      count   <= '0;
      compare <= '1;
      match   <= 1'b0;
      ovf     <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      fcnt    <= '0;
    end else begin
      count <= (wr & sel.cnt) ? WriteData : count + 32'd1;
      if (wr & sel.led) led     <= WriteData[7:0];
      if (wr & sel.cmp) compare <= WriteData;
      // sticky flags: a set in the same cycle beats the W1C
      if (count == compare)                match <= 1'b1;
      else if (wr & sel.sts & WriteData[0]) match <= 1'b0;
      if (drop)                             ovf <= 1'b1;
      else if (wr & sel.sts & WriteData[6]) ovf <= 1'b0;
      if (push_ok) wptr <= nxt(wptr);
      if (pop)     rptr <= nxt(rptr);
      fcnt <= fcnt + CW'(push_ok) - CW'(pop);
    end
  end

  // storage arrays carry no reset; emptiness is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (wr & sel.ram) ram[ridx]  <= WriteData;
    if (push_ok)      fmem[wptr] <= WriteData;
  end

  always_comb begin
    ReadData = '0;
    if (sel.ram)      ReadData = ram[ridx];
    else if (sel.led) ReadData = {24'd0, led};
    else if (sel.cnt) ReadData = count;
    else if (sel.cmp) ReadData = compare;
    else if (sel.sts) ReadData = {25'd0, ovf, 3'(fcnt), empty, full, match};
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized bench for data_bus_responder against a queue-based reference model.
module tb_data_bus_responder;
  localparam int RW = 64;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        out_ready = 1'b0;
  logic [31:0] ReadData, out_data;
  logic [7:0]  led;
  logic        out_valid, irq;

  always #5 clk = ~clk;

  data_bus_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .led(led), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference state
  bit [31:0] m_ram [RW];
  bit        m_rv  [RW];
  bit [7:0]  m_led;
  bit [31:0] m_cnt, m_cmp;
  bit        m_match, m_ovf;
  bit [31:0] q[$];

  logic [31:0] l_rd, l_od;
  logic        l_ov;

  function automatic bit [31:0] m_status();
    return {25'd0, m_ovf, 3'(q.size()), q.size() == 0, q.size() == FD, m_match};
  endfunction

  function automatic bit m_rdok(input bit [31:0] a);
    return (a[31:8] != 0) || m_rv[int'(a[7:2]) % RW];
  endfunction

  function automatic bit [31:0] m_read(input bit [31:0] a);
    if (a[31:8] == 0) return m_ram[int'(a[7:2]) % RW];
    case (a[31:2])
      30'h40:  return {24'd0, m_led};
      30'h41:  return m_cnt;
      30'h42:  return m_cmp;
      30'h43:  return m_status();
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_led = 0; m_cnt = 0; m_cmp = '1; m_match = 0; m_ovf = 0;
    q.delete();
  endtask

  task automatic m_step(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit rdy);
    bit [29:0] w    = a[31:2];
    bit        pop  = (q.size() > 0) && rdy;
    bit        push = we && (w == 30'h44);
    bit        full = (q.size() == FD);
    bit        w1c  = we && (w == 30'h43);
    bit        hit  = (m_cnt == m_cmp);
    m_cnt = (we && w == 30'h41) ? wd : m_cnt + 1;
    if (we && w == 30'h40) m_led = wd[7:0];
    if (we && w == 30'h42) m_cmp = wd;
    if (hit) m_match = 1; else if (w1c && wd[0]) m_match = 0;
    if (push && full && !pop) m_ovf = 1; else if (w1c && wd[6]) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (push && !(full && !pop)) q.push_back(wd);
    if (we && a[31:8] == 0) begin
      m_ram[int'(a[7:2]) % RW] = wd;
      m_rv[int'(a[7:2]) % RW]  = 1;
    end
  endtask

  // one bus cycle: drive after the edge, check mid-cycle, advance model at the edge
  task automatic cyc(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit rdy);
    MemWrite = we; ALUResult = a; WriteData = wd; out_ready = rdy;
    @(negedge clk);
    l_rd = ReadData; l_od = out_data; l_ov = out_valid;
    if (m_rdok(a)) chk("rdata", ReadData, m_read(a));
    chk("led", {24'd0, led}, {24'd0, m_led});
    chk("valid", out_valid, q.size() > 0);
    if (q.size() > 0) chk("odata", out_data, q[0]);
    chk("irq", irq, m_match);
    @(posedge clk);
    m_step(we, a, wd, rdy);
    #1;
  endtask

  bit [31:0] exp4 [4];
  int        r;
  bit [31:0] ra, rwd;
  bit        rwe, rrdy;

  initial begin
    #1 reset = 1'b0;
    m_reset();
    ALUResult = 32'h104; #1;
    chk("rst_count", ReadData, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    ALUResult = 32'h108; #1;
    chk("rst_compare", ReadData, 32'hFFFF_FFFF);
    ALUResult = 32'h10C; #1;
    chk("rst_status", ReadData, 32'h4);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); m_step(MemWrite, ALUResult, WriteData, out_ready); #1;

    // RAM store/load, unmapped read, read independent of MemWrite
    cyc(1, 32'h3C, 32'hDEAD_BEEF, 0);
    cyc(0, 32'h3C, 0, 0);          chk("ram_load", l_rd, 32'hDEAD_BEEF);
    cyc(0, 32'h200, 0, 0);         chk("unmapped", l_rd, 32'd0);
    cyc(1, 32'h200, 32'h1234, 0);  chk("unmapped_we", l_rd, 32'd0);
    cyc(0, 32'h3D, 0, 0);          chk("ram_lowbits", l_rd, 32'hDEAD_BEEF);

    // compare/match/irq and W1C
    cyc(1, 32'h104, 32'd0, 0);
    cyc(1, 32'h108, 32'd10, 0);
    repeat (9) cyc(0, 32'h10C, 0, 0);
    chk("irq_pre", irq, 1'b0);
    cyc(0, 32'h10C, 0, 0);         chk("irq_set", irq, 1'b1);
    cyc(1, 32'h10C, 32'h1, 0);     chk("irq_clr", irq, 1'b0);

    // overflow on a full FIFO, then drain in order
    for (int i = 1; i <= 5; i++) cyc(1, 32'h110, i, 0);
    cyc(0, 32'h10C, 0, 0);         chk("status_full", l_rd, 32'h62);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 32'h10C, 0, 1);       chk("pop_seq", l_od, i);
    end
    cyc(0, 32'h110, 0, 0);         chk("drained", l_ov, 1'b0);
    chk("push_rd0", l_rd, 32'd0);
    cyc(1, 32'h10C, 32'h40, 0);

    // simultaneous push and pop while full
    for (int i = 11; i <= 14; i++) cyc(1, 32'h110, i, 0);
    cyc(1, 32'h110, 32'd9, 1);
    cyc(0, 32'h10C, 0, 0);         chk("status_pp", l_rd, 32'h22);
    exp4[0] = 12; exp4[1] = 13; exp4[2] = 14; exp4[3] = 9;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h10C, 0, 1);       chk("pp_seq", l_od, exp4[i]);
    end

    // asynchronous reset in mid-cycle
    cyc(1, 32'h100, 32'hA5, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 32'h110, 20 + i, 0);
    MemWrite = 0; ALUResult = 32'h104; out_ready = 0;
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_led", {24'd0, led}, 32'd0);
    chk("arst_count", ReadData, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); m_step(0, 32'h104, 0, 0); #1;
    cyc(0, 32'h104, 0, 0);         chk("count_resume", l_rd, 32'd1);
    cyc(0, 32'h3C, 0, 0);          chk("ram_kept", l_rd, 32'hDEAD_BEEF);

    // COUNT wrap with and without a compare hit at 0xFFFFFFFF
    cyc(1, 32'h108, 32'd5, 0);
    cyc(1, 32'h104, 32'hFFFF_FFFF, 0);
    cyc(0, 32'h104, 0, 0);         chk("count_max", l_rd, 32'hFFFF_FFFF);
    cyc(0, 32'h104, 0, 0);         chk("count_wrap", l_rd, 32'd0);
    chk("wrap_nomatch", irq, 1'b0);
    cyc(1, 32'h108, 32'hFFFF_FFFF, 0);
    cyc(1, 32'h104, 32'hFFFF_FFFF, 0);
    cyc(0, 32'h104, 0, 0);
    cyc(0, 32'h104, 0, 0);         chk("count_wrap2", l_rd, 32'd0);
    chk("wrap_match", irq, 1'b1);
    cyc(1, 32'h10C, 32'h41, 0);

    // fill the RAM so every later load has a known value
    for (int i = 0; i < RW; i++) cyc(1, i * 4, $urandom, $urandom_range(0, 1));

    for (int n = 0; n < 3000; n++) begin
      r    = $urandom_range(0, 9);
      rwd  = $urandom;
      rwe  = $urandom_range(0, 1);
      rrdy = ($urandom_range(0, 2) == 0);
      case (r)
        0, 1, 2: ra = {24'd0, 8'($urandom)};
        3: ra = 32'h100;
        4: begin ra = 32'h104; rwd = $urandom_range(0, 40); end
        5: begin ra = 32'h108; rwd = m_cnt + $urandom_range(1, 6); end
        6: ra = 32'h10C;
        7, 8: ra = 32'h110;
        default: begin
          case ($urandom_range(0, 3))
            0: ra = 32'h114;
            1: ra = 32'h200;
            2: ra = {8'($urandom_range(1, 255)), 24'($urandom)};
            default: ra = 32'h118 + 4 * $urandom_range(0, 50);
          endcase
        end
      endcase
      ra[1:0] = 2'($urandom);
      cyc(rwe, ra, rwd, rrdy);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
